// File: rtl/bch_chien_search.sv
// Serial Chien search for the BCH(15,7) decoder over GF(16) (x^4+x+1).
// Evaluates sigma(alpha^-j) for one position per cycle and flips the bits it finds in error.
module bch_chien_search #(
    parameter int unsigned N = 15,
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] lambda1,
    input  logic [M-1:0] lambda2,
    input  logic [N-1:0] rx_word,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] data_out,
    output logic [1:0]   err_count,
    output logic         fail
);

    localparam int unsigned JW    = 4;
    localparam int unsigned J_MAX = N - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Multiply by alpha^-1 (= alpha^14): divide by x modulo x^4+x+1.
    function automatic logic [M-1:0] mul_a14(input logic [M-1:0] v);
        return {v[0], v[3], v[2], v[1] ^ v[0]};
    endfunction

    function automatic logic [M-1:0] mul_a13(input logic [M-1:0] v);
        return mul_a14(mul_a14(v));
    endfunction

    state_t        state, state_nxt;
    logic [N-1:0]  work, work_nxt;
    logic [N-1:0]  rx_lat, rx_lat_nxt;
    logic [M-1:0]  t1, t1_nxt;
    logic [M-1:0]  t2, t2_nxt;
    logic [JW-1:0] j, j_nxt;
    logic [1:0]    root_cnt, root_cnt_nxt;
    logic [1:0]    deg, deg_nxt;
    logic          busy_nxt, done_nxt, fail_nxt;
    logic [N-1:0]  data_out_nxt;
    logic [1:0]    err_count_nxt;
    logic [M-1:0]  s_c;

    assign s_c = M'(1) ^ t1 ^ t2;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        work_nxt      = work;
        rx_lat_nxt    = rx_lat;
        t1_nxt        = t1;
        t2_nxt        = t2;
        j_nxt         = j;
        root_cnt_nxt  = root_cnt;
        deg_nxt       = deg;
        done_nxt      = 1'b0;
        data_out_nxt  = data_out;
        err_count_nxt = err_count;
        fail_nxt      = fail;

        case (state)
            S_IDLE: begin
                if (start) begin
                    work_nxt     = rx_word;
                    rx_lat_nxt   = rx_word;
                    t1_nxt       = lambda1;
                    t2_nxt       = lambda2;
                    j_nxt        = '0;
                    root_cnt_nxt = '0;
                    if (lambda2 != '0)      deg_nxt = 2'd2;
                    else if (lambda1 != '0) deg_nxt = 2'd1;
                    else                    deg_nxt = 2'd0;
                    state_nxt    = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (s_c == '0) begin
                    work_nxt     = work ^ (N'(1) << j);
                    root_cnt_nxt = (root_cnt == 2'd3) ? 2'd3 : root_cnt + 2'd1;
                end
                t1_nxt = mul_a14(t1);
                t2_nxt = mul_a13(t2);
                if (j == JW'(J_MAX)) state_nxt = S_DONE;
                else                 j_nxt     = j + JW'(1);
            end
            S_DONE: begin
                done_nxt = 1'b1;
                if (root_cnt == deg) begin
                    data_out_nxt  = work;
                    err_count_nxt = root_cnt;
                    fail_nxt      = 1'b0;
                end else begin
                    data_out_nxt  = rx_lat;
                    err_count_nxt = 2'd0;
                    fail_nxt      = 1'b1;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt == S_SEARCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            work      <= '0;
            rx_lat    <= '0;
            t1        <= '0;
            t2        <= '0;
            j         <= '0;
            root_cnt  <= '0;
            deg       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            err_count <= '0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            rx_lat    <= rx_lat_nxt;
            t1        <= t1_nxt;
            t2        <= t2_nxt;
            j         <= j_nxt;
            root_cnt  <= root_cnt_nxt;
            deg       <= deg_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            data_out  <= data_out_nxt;
            err_count <= err_count_nxt;
            fail      <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_bch_chien_search.sv
// Scoreboard bench for bch_chien_search: jobs push expected results, a monitor checks each done.
module tb_bch_chien_search;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  lambda1;
    logic [3:0]  lambda2;
    logic [14:0] rx_word;
    logic        busy;
    logic        done;
    logic [14:0] data_out;
    logic [1:0]  err_count;
    logic        fail;

    typedef struct {
        logic [14:0] data;
        logic [1:0]  err;
        logic        fail;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    bch_chien_search #(.N(15), .M(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lambda1   (lambda1),
        .lambda2   (lambda2),
        .rx_word   (rx_word),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .err_count (err_count),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out",  int'(data_out),  int'(e.data));
                check("err_count", int'(err_count), int'(e.err));
                check("fail",      int'(fail),      int'(e.fail));
                check("latency",   cyc,             e.cyc);
            end
        end
    end

    // Issue one job; optionally pulse a second (ignored) start at cycle extra_at.
    task automatic run_job(input logic [3:0] l1, input logic [3:0] l2, input logic [14:0] rx,
                           input logic [14:0] ed, input logic [1:0] ee, input logic ef,
                           input int extra_at);
        exp_t e;
        int   bcnt;
        bcnt    = 0;
        lambda1 = l1;
        lambda2 = l2;
        rx_word = rx;
        start   = 1'b1;
        e.data = ed; e.err = ee; e.fail = ef; e.cyc = cyc + 17;
        exp_q.push_back(e);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start   = 1'b0;
                rx_word = 15'h5A5A;
                lambda1 = 4'h3;
                lambda2 = 4'h7;
            end
            if (i == extra_at) begin
                start   = 1'b1;
                lambda1 = 4'hF;
                lambda2 = 4'hD;
                rx_word = 15'h7BF7;
            end
            if (i == extra_at + 1) start = 1'b0;
            if (busy === 1'b1) bcnt++;
        end
        check("busy_cycles", bcnt, 15);
        check("pending_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; lambda1 = '0; lambda2 = '0; rx_word = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_data",  int'(data_out), 0);
        check("rst_err",   int'(err_count), 0);
        check("rst_fail",  int'(fail), 0);
        rst = 1'b0;
        @(negedge clk);

        run_job(4'h0, 4'h0, 15'h0000, 15'h0000, 2'd0, 1'b0, -10);  // no error
        run_job(4'h6, 4'h0, 15'h0020, 15'h0000, 2'd1, 1'b0, -10);  // bit 5
        run_job(4'hF, 4'hD, 15'h7BF7, 15'h7FFF, 2'd2, 1'b0, -10);  // bits 3,10
        run_job(4'h0, 4'h1, 15'h1234, 15'h1234, 2'd0, 1'b1, -10);  // repeated root
        run_job(4'h0, 4'h0, 15'h2AC3, 15'h2AC3, 2'd0, 1'b0, -10);  // deg 0, nonzero word
        run_job(4'h9, 4'h0, 15'h4000, 15'h0000, 2'd1, 1'b0, -10);  // bit 14
        run_job(4'h8, 4'h9, 15'h4001, 15'h0000, 2'd2, 1'b0, -10);  // bits 0,14
        run_job(4'h6, 4'h0, 15'h0020, 15'h0000, 2'd1, 1'b0, 4);    // start while busy

        // data_out is held after done
        repeat (5) @(negedge clk);
        check("hold_data", int'(data_out), 0);
        check("hold_err",  int'(err_count), 1);

        // Reset in the middle of a double-error search
        lambda1 = 4'hF; lambda2 = 4'hD; rx_word = 15'h7BF7; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 6) rst = 1'b1;
        end
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_data", int'(data_out), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err",  int'(err_count), 0);
        repeat (20) @(negedge clk);
        run_job(4'h0, 4'h0, 15'h0000, 15'h0000, 2'd0, 1'b0, -10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got 1, expected 0");
        $fatal(1);
    end

endmodule
